// File: rtl/memory_stage.sv
// Memory pipeline stage: issues one data-memory request per load/store through a
// small FSM, formats load data and registers the op for the writeback side.
package rvga_pkg;
    typedef struct packed {
        logic       reg_write_v;
        logic       mem_read_v;
        logic       mem_write_v;
        logic [2:0] funct3;
    } rvga_cword_s;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } rvga_dword_s;
endpackage

module memory_stage
    import rvga_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [4:0]  execute_rs1,
    input  logic [4:0]  execute_rs2,
    input  logic [4:0]  execute_rd,
    input  logic [31:0] execute_result,
    input  logic [31:0] execute_data,
    input  rvga_cword_s cword_i,
    input  rvga_dword_s dword_i,
    output logic        dmem_req_v_o,
    output logic        dmem_we_o,
    output logic [31:0] dmem_addr_o,
    output logic [31:0] dmem_wdata_o,
    output logic [3:0]  dmem_wmask_o,
    input  logic        dmem_ready_i,
    input  logic        dmem_rdata_v_i,
    input  logic [31:0] dmem_rdata_i,
    output logic [4:0]  memory_rs1,
    output logic [4:0]  memory_rs2,
    output logic [4:0]  memory_rd,
    output logic [31:0] memory_result,
    output rvga_cword_s cword_o,
    output rvga_dword_s dword_o,
    output logic        memory_misaligned_o,
    output logic        stall_o,
    output logic [1:0]  fsm_state
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] RESP = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    logic [1:0]  state;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_mask;
    logic        req_we;
    logic [2:0]  req_f3;
    logic [31:0] load_data;

    logic        mem_op;
    logic        misaligned;
    logic [3:0]  st_mask;
    logic [31:0] st_wdata;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_fmt;

    assign mem_op = cword_i.mem_read_v | cword_i.mem_write_v;

    // Sizes 011/110/111 are not legal RV32 accesses and are reported like misalignment.
    always_comb begin
        misaligned = 1'b0;
        case (cword_i.funct3)
            3'b011, 3'b110, 3'b111: misaligned = 1'b1;
            default: begin
                if (cword_i.funct3[1:0] == 2'b01)
                    misaligned = execute_result[0];
                else if (cword_i.funct3[1:0] == 2'b10)
                    misaligned = (execute_result[1:0] != 2'b00);
            end
        endcase
        misaligned = misaligned & mem_op;
    end

    always_comb begin
        st_mask  = 4'b1111;
        st_wdata = execute_data;
        case (cword_i.funct3[1:0])
            2'b00: begin
                st_mask  = 4'b0001 << execute_result[1:0];
                st_wdata = {4{execute_data[7:0]}};
            end
            2'b01: begin
                st_mask  = 4'b0011 << execute_result[1:0];
                st_wdata = {2{execute_data[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        ld_byte = dmem_rdata_i[7:0];
        case (req_addr[1:0])
            2'b01:   ld_byte = dmem_rdata_i[15:8];
            2'b10:   ld_byte = dmem_rdata_i[23:16];
            2'b11:   ld_byte = dmem_rdata_i[31:24];
            default: ;
        endcase
        ld_half = req_addr[1] ? dmem_rdata_i[31:16] : dmem_rdata_i[15:0];
        case (req_f3)
            3'b000:  ld_fmt = {{24{ld_byte[7]}}, ld_byte};
            3'b100:  ld_fmt = {24'h0, ld_byte};
            3'b001:  ld_fmt = {{16{ld_half[15]}}, ld_half};
            3'b101:  ld_fmt = {16'h0, ld_half};
            default: ld_fmt = dmem_rdata_i;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state     <= IDLE;
            req_addr  <= '0;
            req_wdata <= '0;
            req_mask  <= '0;
            req_we    <= 1'b0;
            req_f3    <= '0;
            load_data <= '0;
        end else begin
            case (state)
                IDLE: if (mem_op && !misaligned) begin
                    req_addr  <= execute_result;
                    req_wdata <= st_wdata;
                    req_mask  <= st_mask;
                    req_we    <= cword_i.mem_write_v;
                    req_f3    <= cword_i.funct3;
                    state     <= REQ;
                end
                REQ: if (dmem_ready_i) state <= req_we ? DONE : RESP;
                RESP: if (dmem_rdata_v_i) begin
                    load_data <= ld_fmt;
                    state     <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Request fields come only from the captured registers so they stay stable while waiting.
    assign dmem_req_v_o = (state == REQ);
    assign dmem_we_o    = dmem_req_v_o & req_we;
    assign dmem_wmask_o = dmem_req_v_o ? req_mask : 4'b0000;
    assign dmem_addr_o  = {req_addr[31:2], 2'b00};
    assign dmem_wdata_o = req_wdata;
    assign stall_o      = ((state == IDLE) & mem_op & ~misaligned) | (state == REQ) | (state == RESP);
    assign fsm_state    = state;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            memory_rs1          <= '0;
            memory_rs2          <= '0;
            memory_rd           <= '0;
            memory_result       <= '0;
            cword_o             <= '0;
            dword_o             <= '0;
            memory_misaligned_o <= 1'b0;
        end else if (stall_o) begin
            memory_rd           <= '0;
            cword_o             <= '0;
            dword_o             <= '0;
            memory_misaligned_o <= 1'b0;
        end else begin
            memory_rs1          <= execute_rs1;
            memory_rs2          <= execute_rs2;
            memory_rd           <= execute_rd;
            memory_result       <= (cword_i.mem_read_v && !misaligned) ? load_data : execute_result;
            cword_o             <= cword_i;
            dword_o             <= dword_i;
            memory_misaligned_o <= misaligned;
        end
    end

endmodule

// File: tb/tb_memory_stage.sv
// Directed bench for memory_stage: hand-computed store lanes, load formatting,
// misalignment, wait-state timing and reset in the middle of a load.
module tb_memory_stage;
    import rvga_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  execute_rs1, execute_rs2, execute_rd;
    logic [31:0] execute_result, execute_data;
    rvga_cword_s cword_i, cword_o;
    rvga_dword_s dword_i, dword_o;
    logic        dmem_req_v_o, dmem_we_o;
    logic [31:0] dmem_addr_o, dmem_wdata_o;
    logic [3:0]  dmem_wmask_o;
    logic        dmem_ready_i, dmem_rdata_v_i;
    logic [31:0] dmem_rdata_i;
    logic [4:0]  memory_rs1, memory_rs2, memory_rd;
    logic [31:0] memory_result;
    logic        memory_misaligned_o, stall_o;
    logic [1:0]  fsm_state;

    int n_total = 0;
    int n_bad   = 0;

    memory_stage dut (
        .clk_i(clk), .rst_i(rst),
        .execute_rs1(execute_rs1), .execute_rs2(execute_rs2), .execute_rd(execute_rd),
        .execute_result(execute_result), .execute_data(execute_data),
        .cword_i(cword_i), .dword_i(dword_i),
        .dmem_req_v_o(dmem_req_v_o), .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o),
        .dmem_wdata_o(dmem_wdata_o), .dmem_wmask_o(dmem_wmask_o),
        .dmem_ready_i(dmem_ready_i), .dmem_rdata_v_i(dmem_rdata_v_i), .dmem_rdata_i(dmem_rdata_i),
        .memory_rs1(memory_rs1), .memory_rs2(memory_rs2), .memory_rd(memory_rd),
        .memory_result(memory_result), .cword_o(cword_o), .dword_o(dword_o),
        .memory_misaligned_o(memory_misaligned_o), .stall_o(stall_o), .fsm_state(fsm_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic settle;
        #1;
    endtask

    function automatic rvga_cword_s make_cw(input logic rw, input logic mr, input logic mw,
                                            input logic [2:0] f3);
        rvga_cword_s c;
        c.reg_write_v = rw;
        c.mem_read_v  = mr;
        c.mem_write_v = mw;
        c.funct3      = f3;
        return c;
    endfunction

    // driver tasks
    task automatic drive_op(input rvga_cword_s cw, input logic [4:0] rs1, input logic [4:0] rs2,
                            input logic [4:0] rd, input logic [31:0] res, input logic [31:0] data);
        cword_i        = cw;
        dword_i.pc     = 32'h1000 + {27'h0, rd};
        dword_i.instr  = 32'h00000013;
        execute_rs1    = rs1;
        execute_rs2    = rs2;
        execute_rd     = rd;
        execute_result = res;
        execute_data   = data;
    endtask

    task automatic set_nop;
        drive_op('0, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0);
        dword_i = '0;
    endtask

    // One aligned load or store with zero memory wait states.
    task automatic run_mem(input string tag, input logic ld, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] data,
                           input logic [31:0] rdata, input logic [3:0] exp_mask,
                           input logic [31:0] exp_wdata, input logic [31:0] exp_res,
                           input logic [4:0] rd);
        drive_op(make_cw(ld, ld, ~ld, f3), 5'd1, 5'd2, rd, addr, data);
        settle();
        check({tag, " entry stall"}, {31'h0, stall_o}, 32'h1);
        check({tag, " entry req_v"}, {31'h0, dmem_req_v_o}, 32'h0);
        tick();
        check({tag, " req_v"}, {31'h0, dmem_req_v_o}, 32'h1);
        check({tag, " addr"}, dmem_addr_o, {addr[31:2], 2'b00});
        check({tag, " we"}, {31'h0, dmem_we_o}, {31'h0, ~ld});
        if (!ld) begin
            check({tag, " mask"}, {28'h0, dmem_wmask_o}, {28'h0, exp_mask});
            check({tag, " wdata"}, dmem_wdata_o, exp_wdata);
        end
        dmem_ready_i = 1'b1;
        tick();
        dmem_ready_i = 1'b0;
        if (ld) begin
            check({tag, " resp state"}, {30'h0, fsm_state}, 32'd2);
            check({tag, " resp req_v"}, {31'h0, dmem_req_v_o}, 32'h0);
            dmem_rdata_v_i = 1'b1;
            dmem_rdata_i   = rdata;
            tick();
            dmem_rdata_v_i = 1'b0;
            dmem_rdata_i   = 32'h0;
        end
        check({tag, " done state"}, {30'h0, fsm_state}, 32'd3);
        check({tag, " done stall"}, {31'h0, stall_o}, 32'h0);
        check({tag, " done mask"}, {28'h0, dmem_wmask_o}, 32'h0);
        check({tag, " bubble rd"}, {27'h0, memory_rd}, 32'h0);
        tick();
        set_nop();
        check({tag, " result"}, memory_result, exp_res);
        check({tag, " rd"}, {27'h0, memory_rd}, {27'h0, rd});
        check({tag, " cw read"}, {31'h0, cword_o.mem_read_v}, {31'h0, ld});
        check({tag, " idle"}, {30'h0, fsm_state}, 32'd0);
    endtask

    task automatic run_mis(input string tag, input logic ld, input logic [2:0] f3,
                           input logic [31:0] addr);
        drive_op(make_cw(ld, ld, ~ld, f3), 5'd3, 5'd4, 5'd6, addr, 32'h55);
        settle();
        check({tag, " stall"}, {31'h0, stall_o}, 32'h0);
        check({tag, " req_v"}, {31'h0, dmem_req_v_o}, 32'h0);
        tick();
        set_nop();
        check({tag, " misaligned"}, {31'h0, memory_misaligned_o}, 32'h1);
        check({tag, " result"}, memory_result, addr);
        check({tag, " state"}, {30'h0, fsm_state}, 32'd0);
        tick();
        check({tag, " clear"}, {31'h0, memory_misaligned_o}, 32'h0);
    endtask

    initial begin
        rst            = 1'b1;
        dmem_ready_i   = 1'b0;
        dmem_rdata_v_i = 1'b0;
        dmem_rdata_i   = 32'h0;
        set_nop();
        tick();
        tick();
        rst = 1'b0;
        settle();
        check("reset result", memory_result, 32'h0);
        check("reset rd", {27'h0, memory_rd}, 32'h0);
        check("reset state", {30'h0, fsm_state}, 32'd0);
        check("reset stall", {31'h0, stall_o}, 32'h0);
        check("reset req_v", {31'h0, dmem_req_v_o}, 32'h0);

        // ALU op passes straight through in one cycle
        drive_op(make_cw(1'b1, 1'b0, 1'b0, 3'b000), 5'd1, 5'd2, 5'd5, 32'h1234, 32'h0);
        settle();
        check("add stall", {31'h0, stall_o}, 32'h0);
        tick();
        set_nop();
        check("add result", memory_result, 32'h1234);
        check("add rd", {27'h0, memory_rd}, 32'd5);
        check("add cw", {31'h0, cword_o.reg_write_v}, 32'h1);

        run_mem("sb",  1'b0, 3'b000, 32'h103, 32'h000000AB, 32'h0, 4'b1000, 32'hABABABAB, 32'h103, 5'd0);
        run_mem("sb2", 1'b0, 3'b000, 32'h101, 32'h123456C7, 32'h0, 4'b0010, 32'hC7C7C7C7, 32'h101, 5'd0);
        run_mem("sh",  1'b0, 3'b001, 32'h302, 32'h1234ABCD, 32'h0, 4'b1100, 32'hABCDABCD, 32'h302, 5'd0);
        run_mem("sw",  1'b0, 3'b010, 32'h300, 32'hCAFEF00D, 32'h0, 4'b1111, 32'hCAFEF00D, 32'h300, 5'd0);
        run_mem("lbu", 1'b1, 3'b100, 32'h101, 32'h0, 32'h1122F344, 4'b0, 32'h0, 32'h000000F3, 5'd8);
        run_mem("lb",  1'b1, 3'b000, 32'h102, 32'h0, 32'h11803344, 4'b0, 32'h0, 32'hFFFFFF80, 5'd9);
        run_mem("lw",  1'b1, 3'b010, 32'h204, 32'h0, 32'h89ABCDEF, 4'b0, 32'h0, 32'h89ABCDEF, 5'd10);
        run_mem("lhu", 1'b1, 3'b101, 32'h200, 32'h0, 32'h12349876, 4'b0, 32'h0, 32'h00009876, 5'd11);

        // LH with two ready wait states and three response wait states
        drive_op(make_cw(1'b1, 1'b1, 1'b0, 3'b001), 5'd1, 5'd2, 5'd7, 32'h202, 32'h0);
        tick();
        for (int i = 0; i < 2; i++) begin
            dmem_rdata_v_i = 1'b1;
            dmem_rdata_i   = 32'hDEADBEEF;
            settle();
            check("lh wait stall", {31'h0, stall_o}, 32'h1);
            check("lh wait req_v", {31'h0, dmem_req_v_o}, 32'h1);
            check("lh wait addr", dmem_addr_o, 32'h200);
            tick();
        end
        dmem_rdata_v_i = 1'b0;
        dmem_ready_i   = 1'b1;
        tick();
        dmem_ready_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("lh resp stall", {31'h0, stall_o}, 32'h1);
            check("lh resp state", {30'h0, fsm_state}, 32'd2);
            tick();
        end
        dmem_rdata_v_i = 1'b1;
        dmem_rdata_i   = 32'h80015555;
        tick();
        dmem_rdata_v_i = 1'b0;
        check("lh done stall", {31'h0, stall_o}, 32'h0);
        tick();
        set_nop();
        check("lh result", memory_result, 32'hFFFF8001);
        check("lh rd", {27'h0, memory_rd}, 32'd7);

        run_mis("lw mis", 1'b1, 3'b010, 32'h201);
        run_mis("sh mis", 1'b0, 3'b001, 32'h301);
        run_mis("ld size", 1'b1, 3'b011, 32'h200);

        // reset lands while a load waits for its response
        drive_op(make_cw(1'b1, 1'b0, 1'b0, 3'b000), 5'd3, 5'd4, 5'd12, 32'h5555, 32'h0);
        tick();
        drive_op(make_cw(1'b1, 1'b1, 1'b0, 3'b100), 5'd1, 5'd2, 5'd9, 32'h100, 32'h0);
        tick();
        dmem_ready_i = 1'b1;
        tick();
        dmem_ready_i = 1'b0;
        check("rst pre state", {30'h0, fsm_state}, 32'd2);
        check("rst pre hold", memory_result, 32'h5555);
        rst = 1'b1;
        set_nop();
        tick();
        rst = 1'b0;
        check("rst state", {30'h0, fsm_state}, 32'd0);
        check("rst req_v", {31'h0, dmem_req_v_o}, 32'h0);
        check("rst stall", {31'h0, stall_o}, 32'h0);
        check("rst result", memory_result, 32'h0);
        check("rst rs1", {27'h0, memory_rs1}, 32'h0);
        dmem_rdata_v_i = 1'b1;
        dmem_rdata_i   = 32'h000000FF;
        tick();
        dmem_rdata_v_i = 1'b0;
        check("late resp state", {30'h0, fsm_state}, 32'd0);
        check("late resp result", memory_result, 32'h0);
        check("late resp rd", {27'h0, memory_rd}, 32'h0);

        // final report
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
